// File: rtl/shake_arb_pkg.sv
// ============================================================================
// Module      : shake_arb_pkg
// Description : Shared FSM state encoding and default sizing for shake_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package shake_arb_pkg;

   localparam int NREQ_DEFAULT        = 3;
   localparam int MSG_W_DEFAULT       = 260;
   localparam int OUT_W_DEFAULT       = 5000;
   localparam int TIMEOUT_CYC_DEFAULT = 4096;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CLR  = 2'd1,
      RUN  = 2'd2,
      RESP = 2'd3
   } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin pick: first set req bit at or after
//               ptr, wrapping, returned as one-hot sel and binary idx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
   import shake_arb_pkg::*;
#(
   parameter int NREQ  = NREQ_DEFAULT,
   parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic [NREQ-1:0]  req,
   input  logic [IDX_W-1:0] ptr,
   output logic [NREQ-1:0]  sel,
   output logic [IDX_W-1:0] idx
);

   always_comb begin
      logic             found;
      logic [IDX_W-1:0] cand;
      sel   = '0;
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IDX_W'((int'(ptr) + i) % NREQ);
         if (!found && req[cand]) begin
            found     = 1'b1;
            sel[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/shake_arbiter.sv
// ============================================================================
// Module      : shake_arbiter
// Description : Round-robin time-sharing of one SHAKE sponge between NREQ
//               consumers. Optional RUN watchdog: SHAKE_ARB_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module shake_arbiter
   import shake_arb_pkg::*;
#(
   parameter int NREQ        = NREQ_DEFAULT,
   parameter int MSG_W       = MSG_W_DEFAULT,
   parameter int OUT_W       = OUT_W_DEFAULT,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*MSG_W-1:0] msg,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [OUT_W-1:0]      rsp_data,
   output logic                  busy,
   output logic                  err,
   output logic                  sp_rst,
   output logic                  sp_start,
   output logic [MSG_W-1:0]      sp_msg,
   input  logic                  sp_done,
   input  logic [OUT_W-1:0]      sp_z
);

   localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

   arb_state_e       state_q, state_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic [MSG_W-1:0] sp_msg_q, sp_msg_d;
   logic [OUT_W-1:0] rsp_data_q, rsp_data_d;
   logic [NREQ-1:0]  pick_sel;
   logic [IDX_W-1:0] pick_idx;

`ifdef SHAKE_ARB_TIMEOUT_EN
   logic [31:0] cnt_q, cnt_d;
   logic        err_q, err_d;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
`endif

   rr_pick #(
      .NREQ  (NREQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .req (req),
      .ptr (ptr_q),
      .sel (pick_sel),
      .idx (pick_idx)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      ptr_d      = ptr_q;
      sp_msg_d   = sp_msg_q;
      rsp_data_d = rsp_data_q;
`ifdef SHAKE_ARB_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (|req) begin
               state_d  = CLR;
               gnt_d    = pick_sel;
               ptr_d    = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
               sp_msg_d = msg[int'(pick_idx)*MSG_W +: MSG_W];
            end
         end
         CLR: begin
            // sp_done is deliberately not looked at here: the sponge is in reset.
            state_d = RUN;
`ifdef SHAKE_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         RUN: begin
            if (sp_done) begin
               rsp_data_d = sp_z;
               state_d    = RESP;
            end
`ifdef SHAKE_ARB_TIMEOUT_EN
            else if (cnt_q == 32'(TIMEOUT_CYC)) begin
               rsp_data_d = '0;
               err_d      = 1'b1;
               state_d    = RESP;
            end else begin
               cnt_d = cnt_q + 32'd1;
            end
`endif
         end
         RESP: begin
            gnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         gnt_q      <= '0;
         ptr_q      <= '0;
         sp_msg_q   <= '0;
         rsp_data_q <= '0;
`ifdef SHAKE_ARB_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         ptr_q      <= ptr_d;
         sp_msg_q   <= sp_msg_d;
         rsp_data_q <= rsp_data_d;
`ifdef SHAKE_ARB_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign gnt       = gnt_q;
   assign rsp_valid = (state_q == RESP) ? gnt_q : '0;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != IDLE);
   assign sp_rst    = rst | (state_q == CLR);
   assign sp_start  = (state_q == RUN);
   assign sp_msg    = sp_msg_q;
`ifdef SHAKE_ARB_TIMEOUT_EN
   assign err       = err_q;
`else
   assign err       = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_shake_arbiter.sv
// ============================================================================
// Module      : tb_shake_arbiter
// Description : Directed bench for shake_arbiter with a 30-cycle sponge model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_shake_arbiter;

   localparam int NREQ        = 3;
   localparam int MSG_W       = 260;
   localparam int OUT_W       = 5000;
   localparam int TIMEOUT_CYC = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req;
   logic [NREQ*MSG_W-1:0] msg;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       rsp_valid;
   logic [OUT_W-1:0]      rsp_data;
   logic                  busy, err, sp_rst, sp_start, sp_done;
   logic [MSG_W-1:0]      sp_msg;
   logic [OUT_W-1:0]      sp_z;

   int checks = 0;
   int errors = 0;

   logic [MSG_W-1:0] msg_a, msg_b, msg_c, msg_d;
   logic             hang;
   int               mcnt;

   always #5 clk = ~clk;

   shake_arbiter #(
      .NREQ        (NREQ),
      .MSG_W       (MSG_W),
      .OUT_W       (OUT_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .msg       (msg),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .err       (err),
      .sp_rst    (sp_rst),
      .sp_start  (sp_start),
      .sp_msg    (sp_msg),
      .sp_done   (sp_done),
      .sp_z      (sp_z)
   );

   function automatic logic [OUT_W-1:0] h(input logic [MSG_W-1:0] m);
      logic [OUT_W-1:0] r;
      for (int i = 0; i < OUT_W; i++) r[i] = m[i % MSG_W] ^ ((i % 3) == 0);
      return r;
   endfunction

   // Sponge model: done on the 30th cycle of sp_start after a reset.
   always @(posedge clk) begin
      if (sp_rst) mcnt <= 0;
      else if (sp_start && mcnt < 1000) mcnt <= mcnt + 1;
   end
   assign sp_done = !hang && sp_start && (mcnt >= 29);
   assign sp_z    = sp_done ? h(sp_msg) : '0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rsp(input int start, input int limit, output int cyc);
      cyc = start;
      while (rsp_valid == '0 && cyc < limit) begin
         tick();
         cyc++;
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      req = '0;
      tick();
      tick();
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL rst_gnt: got %b want 000", gnt); end
      checks++; if (rsp_valid !== 3'b000) begin errors++; $display("FAIL rst_rsp_valid: got %b want 000", rsp_valid); end
      checks++; if ({busy, err, sp_start} !== 3'b000) begin errors++; $display("FAIL rst_busy_err_start: got %b want 000", {busy, err, sp_start}); end
      checks++; if (sp_rst !== 1'b1) begin errors++; $display("FAIL rst_sp_rst: got %b want 1", sp_rst); end
      checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data: got %h want 0", rsp_data[31:0]); end
      checks++; if (sp_msg !== '0) begin errors++; $display("FAIL rst_sp_msg: got %h want 0", sp_msg[31:0]); end
      rst = 1'b0;
      tick();
      checks++; if (sp_rst !== 1'b0) begin errors++; $display("FAIL rst_release_sp_rst: got %b want 0", sp_rst); end
   endtask

   task automatic test_single;
      int cyc;
      logic [OUT_W-1:0] exp;
      do_reset();
      exp = h(msg_a);
      req = 3'b001;
      tick();
      checks++; if (gnt !== 3'b001 || busy !== 1'b1) begin errors++; $display("FAIL single_gnt: got gnt=%b busy=%b want 001/1", gnt, busy); end
      checks++; if (sp_rst !== 1'b1 || sp_start !== 1'b0) begin errors++; $display("FAIL single_clr: got rst=%b start=%b want 1/0", sp_rst, sp_start); end
      tick();
      checks++; if (sp_rst !== 1'b0 || sp_start !== 1'b1) begin errors++; $display("FAIL single_run: got rst=%b start=%b want 0/1", sp_rst, sp_start); end
      wait_rsp(2, 200, cyc);
      checks++; if (cyc != 32) begin errors++; $display("FAIL single_latency: got cycle %0d want 32", cyc); end
      checks++; if (rsp_valid !== 3'b001) begin errors++; $display("FAIL single_rsp_valid: got %b want 001", rsp_valid); end
      checks++; if (rsp_data !== exp) begin errors++; $display("FAIL single_rsp_data: got %h want %h", rsp_data[31:0], exp[31:0]); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", err); end
      req = '0;
      tick();
      checks++; if ({rsp_valid, gnt, busy} !== 7'b0) begin errors++; $display("FAIL single_idle: got %b want 0000000", {rsp_valid, gnt, busy}); end
   endtask

   task automatic test_contention;
      logic [NREQ-1:0]  exp_g [4];
      logic [MSG_W-1:0] exp_m [4];
      int cyc, n;
      exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
      exp_m = '{msg_a, msg_b, msg_c, msg_a};
      do_reset();
      req = 3'b111;
      for (int k = 0; k < 4; k++) begin
         n = 0;
         while (gnt == '0 && n < 10) begin
            tick();
            n++;
         end
         checks++; if (gnt !== exp_g[k]) begin errors++; $display("FAIL cont_gnt%0d: got %b want %b", k, gnt, exp_g[k]); end
         wait_rsp(1, 200, cyc);
         checks++; if (cyc != 32 || rsp_valid !== exp_g[k]) begin errors++; $display("FAIL cont_rsp%0d: got cycle %0d valid %b want 32 %b", k, cyc, rsp_valid, exp_g[k]); end
         checks++; if (rsp_data !== h(exp_m[k])) begin errors++; $display("FAIL cont_data%0d: got %h want %h", k, rsp_data[31:0], h(exp_m[k]) & 32'hFFFF_FFFF); end
         tick();
      end
      req = '0;
      tick();
   endtask

   task automatic test_msg_change;
      int cyc;
      do_reset();
      req = 3'b001;
      tick();
      msg = {msg_c, msg_b, msg_d};
      tick();
      checks++; if (sp_msg !== msg_a) begin errors++; $display("FAIL chg_sp_msg: got %h want %h", sp_msg[31:0], msg_a[31:0]); end
      wait_rsp(2, 200, cyc);
      checks++; if (rsp_valid !== 3'b001 || rsp_data !== h(msg_a)) begin errors++; $display("FAIL chg_rsp_data: got %h valid %b want %h 001", rsp_data[31:0], rsp_valid, h(msg_a) & 32'hFFFF_FFFF); end
      req = '0;
      msg = {msg_c, msg_b, msg_a};
      tick();
   endtask

   task automatic test_reset_mid_run;
      int cyc, seen;
      do_reset();
      req = 3'b001;
      tick();
      cyc = 1;
      while (cyc < 10) begin
         tick();
         cyc++;
      end
      rst = 1'b1;
      req = '0;
      tick();
      checks++; if (gnt !== 3'b000 || busy !== 1'b0 || rsp_valid !== 3'b000) begin errors++; $display("FAIL midrst_state: got gnt=%b busy=%b valid=%b want 000/0/000", gnt, busy, rsp_valid); end
      checks++; if (sp_rst !== 1'b1) begin errors++; $display("FAIL midrst_sp_rst: got %b want 1", sp_rst); end
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (rsp_valid != '0 || busy) seen++;
      end
      checks++; if (seen != 0) begin errors++; $display("FAIL midrst_quiet: got %0d active cycles want 0", seen); end
      // ptr must be back at 0: with 011 pending, requester 0 wins.
      req = 3'b011;
      tick();
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL midrst_ptr: got %b want 001", gnt); end
      wait_rsp(1, 200, cyc);
      checks++; if (cyc != 32 || rsp_data !== h(msg_a)) begin errors++; $display("FAIL midrst_rsp0: got cycle %0d data %h want 32 %h", cyc, rsp_data[31:0], h(msg_a) & 32'hFFFF_FFFF); end
      req = 3'b010;
      tick();
      tick();
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL midrst_gnt1: got %b want 010", gnt); end
      wait_rsp(1, 200, cyc);
      checks++; if (cyc != 32 || rsp_valid !== 3'b010 || rsp_data !== h(msg_b)) begin errors++; $display("FAIL midrst_rsp1: got cycle %0d valid %b want 32 010", cyc, rsp_valid); end
      req = '0;
      tick();
   endtask

   task automatic test_dropped_req;
      int cyc;
      do_reset();
      req = 3'b010;
      tick();
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL drop_gnt: got %b want 010", gnt); end
      for (int i = 0; i < 4; i++) tick();
      req = '0;
      wait_rsp(5, 200, cyc);
      checks++; if (cyc != 32 || rsp_valid !== 3'b010) begin errors++; $display("FAIL drop_rsp: got cycle %0d valid %b want 32 010", cyc, rsp_valid); end
      checks++; if (rsp_data !== h(msg_b)) begin errors++; $display("FAIL drop_data: got %h want %h", rsp_data[31:0], h(msg_b) & 32'hFFFF_FFFF); end
      tick();
      checks++; if (busy !== 1'b0 || gnt !== 3'b000) begin errors++; $display("FAIL drop_idle: got busy=%b gnt=%b want 0/000", busy, gnt); end
      tick();
      checks++; if (busy !== 1'b0 || rsp_valid !== 3'b000) begin errors++; $display("FAIL drop_stay_idle: got busy=%b valid=%b want 0/000", busy, rsp_valid); end
   endtask

`ifdef SHAKE_ARB_TIMEOUT_EN
   task automatic test_timeout;
      int cyc;
      hang = 1'b1;
      req  = 3'b001;
      tick();
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL to_gnt: got %b want 001", gnt); end
      wait_rsp(1, 200, cyc);
      checks++; if (cyc != 19 || rsp_valid !== 3'b001) begin errors++; $display("FAIL to_rsp: got cycle %0d valid %b want 19 001", cyc, rsp_valid); end
      checks++; if (err !== 1'b1 || rsp_data !== '0) begin errors++; $display("FAIL to_err_data: got err=%b data=%h want 1 0", err, rsp_data[31:0]); end
      req = '0;
      tick();
      checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL to_after: got err=%b busy=%b want 0/0", err, busy); end
      hang = 1'b0;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      msg_a = {65{4'h3}};
      msg_b = {65{4'hC}};
      msg_c = {65{4'h5}};
      msg_d = {13{20'h1_2345}};
      msg   = {msg_c, msg_b, msg_a};
      hang  = 1'b0;
      rst   = 1'b1;
      req   = '0;
      test_reset();
      test_single();
      test_contention();
      test_msg_change();
      test_reset_mid_run();
      test_dropped_req();
`ifdef SHAKE_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
